// File: rtl/button_event_gen_pkg.sv
// Shared definitions for the key event generator and the control FSM that
// consumes its events: state encoding and default tick constants.
package button_event_gen_pkg;

    // Key hold states; IDLE must stay at 2'b00 because the control FSM relies on it.
    typedef enum logic [1:0] {
        ST_IDLE      = 2'b00,
        ST_PRESSED   = 2'b01,
        ST_LONG_HELD = 2'b10
    } state_e;

    localparam int unsigned DEF_LONG_TICKS   = 8;
    localparam int unsigned DEF_REPEAT_TICKS = 4;
    localparam int unsigned DEF_CNT_W        = 8;

endpackage

// File: rtl/button_event_gen_hold_counter.sv
// Hold-time counter for button_event_gen: CNT_W-bit up-counter with
// synchronous clear, count enable and an equality terminal-compare output.
module hold_counter #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clr_i,
    input  logic             en_i,
    input  logic [CNT_W-1:0] term_val_i,
    output logic             term_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: clear has priority over enable; otherwise hold.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Count register.
    // NOTE: sequential state uses non-blocking assignments only, so all registers update together.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Equality compare; the controller never lets the count run past the terminal value.
    assign term_o = (cnt_q == term_val_i);

endmodule

// File: rtl/button_event_gen.sv
// Converts a debounced key level into single-cycle press / release /
// long-press / auto-repeat events. All outputs are registered.
// Optional auto-repeat is enabled by defining BUTTON_EVENT_AUTO_REPEAT_EN;
// without it repeat_pulse is tied 0 and the counter idles in LONG_HELD.
module button_event_gen
    import button_event_gen_pkg::*;
#(
    parameter int unsigned LONG_TICKS   = DEF_LONG_TICKS,
    parameter int unsigned REPEAT_TICKS = DEF_REPEAT_TICKS,
    parameter int unsigned CNT_W        = DEF_CNT_W
) (
    input  logic clk,
    input  logic reset_n,
    input  logic level_in,
    output logic press_pulse,
    output logic release_pulse,
    output logic release_was_long,
    output logic long_pulse,
    output logic repeat_pulse,
    output logic held
);

    localparam logic [CNT_W-1:0] LONG_TERM = CNT_W'(LONG_TICKS - 1);
`ifdef BUTTON_EVENT_AUTO_REPEAT_EN
    localparam logic [CNT_W-1:0] REPEAT_TERM = CNT_W'(REPEAT_TICKS - 1);
`endif

    state_e           state_q;
    logic             press_q;
    logic             release_q;
    logic             was_long_q;
    logic             long_q;
    logic             held_q;
`ifdef BUTTON_EVENT_AUTO_REPEAT_EN
    logic             repeat_q;
`endif

    logic             cnt_en;
    logic             cnt_clr;
    logic             cnt_term;
    logic [CNT_W-1:0] term_val;

    // Counter control: count only while held and short of the terminal value;
    // any other situation (state change, release, idle) clears it.
    always_comb begin
        cnt_en   = 1'b0;
        term_val = LONG_TERM;
        if (state_q == ST_PRESSED) begin
            cnt_en = level_in && !cnt_term;
        end
`ifdef BUTTON_EVENT_AUTO_REPEAT_EN
        if (state_q == ST_LONG_HELD) begin
            term_val = REPEAT_TERM;
            cnt_en   = level_in && !cnt_term;
        end
`endif
        cnt_clr = !cnt_en;
    end

    hold_counter #(
        .CNT_W (CNT_W)
    ) u_hold_counter (
        .clk        (clk),
        .reset_n    (reset_n),
        .clr_i      (cnt_clr),
        .en_i       (cnt_en),
        .term_val_i (term_val),
        .term_o     (cnt_term)
    );

    // Hold FSM with registered event pulses; release is checked before the
    // threshold so a release on the threshold edge suppresses long_pulse.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            press_q    <= 1'b0;
            release_q  <= 1'b0;
            was_long_q <= 1'b0;
            long_q     <= 1'b0;
            held_q     <= 1'b0;
`ifdef BUTTON_EVENT_AUTO_REPEAT_EN
            repeat_q   <= 1'b0;
`endif
        end else begin
            press_q    <= 1'b0;
            release_q  <= 1'b0;
            was_long_q <= 1'b0;
            long_q     <= 1'b0;
`ifdef BUTTON_EVENT_AUTO_REPEAT_EN
            repeat_q   <= 1'b0;
`endif
            unique case (state_q)
                ST_IDLE: begin
                    if (level_in) begin
                        state_q <= ST_PRESSED;
                        press_q <= 1'b1;
                        held_q  <= 1'b1;
                    end
                end
                ST_PRESSED: begin
                    if (!level_in) begin
                        state_q   <= ST_IDLE;
                        release_q <= 1'b1;
                        held_q    <= 1'b0;
                    end else if (cnt_term) begin
                        state_q <= ST_LONG_HELD;
                        long_q  <= 1'b1;
                    end
                end
                ST_LONG_HELD: begin
                    if (!level_in) begin
                        state_q    <= ST_IDLE;
                        release_q  <= 1'b1;
                        was_long_q <= 1'b1;
                        held_q     <= 1'b0;
                    end
`ifdef BUTTON_EVENT_AUTO_REPEAT_EN
                    else if (cnt_term) begin
                        repeat_q <= 1'b1;
                    end
`endif
                end
                default: begin
                    state_q <= ST_IDLE;
                    held_q  <= 1'b0;
                end
            endcase
        end
    end

    assign press_pulse      = press_q;
    assign release_pulse    = release_q;
    assign release_was_long = was_long_q;
    assign long_pulse       = long_q;
    assign held             = held_q;
`ifdef BUTTON_EVENT_AUTO_REPEAT_EN
    assign repeat_pulse     = repeat_q;
`else
    assign repeat_pulse     = 1'b0;
`endif

endmodule

// File: tb/tb_button_event_gen.sv
// Directed self-checking bench for button_event_gen (LONG_TICKS=8, REPEAT_TICKS=4).
// Output vector order: {press, release, release_was_long, long, repeat, held}.
module tb_button_event_gen;

    logic clk;
    logic reset_n;
    logic level_in;
    logic press_pulse;
    logic release_pulse;
    logic release_was_long;
    logic long_pulse;
    logic repeat_pulse;
    logic held;

    int checks;
    int failures;
    bit mon_en;

    button_event_gen #(
        .LONG_TICKS   (8),
        .REPEAT_TICKS (4),
        .CNT_W        (8)
    ) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .level_in         (level_in),
        .press_pulse      (press_pulse),
        .release_pulse    (release_pulse),
        .release_was_long (release_was_long),
        .long_pulse       (long_pulse),
        .repeat_pulse     (repeat_pulse),
        .held             (held)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [5:0] obs();
        return {press_pulse, release_pulse, release_was_long, long_pulse, repeat_pulse, held};
    endfunction

    // Apply one level for one edge, then sample just after the edge.
    task automatic tick(input logic lvl);
        level_in = lvl;
        @(posedge clk);
        #1;
    endtask

    // Pulses must be mutually exclusive and release_was_long only with release.
    always @(negedge clk) begin
        if (mon_en) begin
            checks++;
            if (($countones({press_pulse, release_pulse, long_pulse, repeat_pulse}) > 1) ||
                (release_was_long && !release_pulse)) begin
                failures++;
                $display("FAIL onehot t=%0t got=%b exp=at most one pulse", $time, obs());
            end
        end
    end

    task automatic test_reset();
        reset_n  = 1'b0;
        level_in = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (obs() !== 6'b000000) begin
            failures++;
            $display("FAIL reset_outputs got=%b exp=%b", obs(), 6'b000000);
        end
        reset_n = 1'b1;
        mon_en  = 1'b1;
        tick(1'b0);
        checks++;
        if (obs() !== 6'b000000) begin
            failures++;
            $display("FAIL reset_idle got=%b exp=%b", obs(), 6'b000000);
        end
    endtask

    // Press sampled on 4 edges then released: release 4 cycles after press.
    task automatic test_short_press();
        logic [5:0] exp;
        for (int i = 0; i < 6; i++) begin
            tick(i < 4);
            if (i == 0)      exp = 6'b100001;
            else if (i < 4)  exp = 6'b000001;
            else if (i == 4) exp = 6'b010000;
            else             exp = 6'b000000;
            checks++;
            if (obs() !== exp) begin
                failures++;
                $display("FAIL short_press i=%0d got=%b exp=%b", i, obs(), exp);
            end
        end
    endtask

    // Hold 20 edges: long at +8 after press; repeats at +4/+8 after long if enabled.
    task automatic test_long_and_repeat();
        logic [5:0] exp;
        for (int i = 0; i < 22; i++) begin
            tick(i < 20);
            if (i == 0)       exp = 6'b100001;
            else if (i == 8)  exp = 6'b000101;
`ifdef BUTTON_EVENT_AUTO_REPEAT_EN
            else if (i == 12 || i == 16) exp = 6'b000011;
`endif
            else if (i < 20)  exp = 6'b000001;
            else if (i == 20) exp = 6'b011000;
            else              exp = 6'b000000;
            checks++;
            if (obs() !== exp) begin
                failures++;
                $display("FAIL long_repeat i=%0d got=%b exp=%b", i, obs(), exp);
            end
        end
    endtask

    // Release on the threshold edge: release only, not long.
    task automatic test_threshold_release();
        logic [5:0] exp;
        for (int i = 0; i < 10; i++) begin
            tick(i < 8);
            if (i == 0)      exp = 6'b100001;
            else if (i < 8)  exp = 6'b000001;
            else if (i == 8) exp = 6'b010000;
            else             exp = 6'b000000;
            checks++;
            if (obs() !== exp) begin
                failures++;
                $display("FAIL threshold_release i=%0d got=%b exp=%b", i, obs(), exp);
            end
        end
    endtask

    // Reset asserted mid-hold with level still high: outputs drop at once, fresh press after.
    task automatic test_reset_mid_hold();
        logic [5:0] exp;
        for (int i = 0; i < 6; i++) begin
            tick(1'b1);
            exp = (i == 0) ? 6'b100001 : 6'b000001;
            checks++;
            if (obs() !== exp) begin
                failures++;
                $display("FAIL mid_hold_pre i=%0d got=%b exp=%b", i, obs(), exp);
            end
        end
        reset_n = 1'b0;
        #1;
        checks++;
        if (obs() !== 6'b000000) begin
            failures++;
            $display("FAIL mid_hold_async got=%b exp=%b", obs(), 6'b000000);
        end
        for (int i = 0; i < 2; i++) begin
            tick(1'b1);
            checks++;
            if (obs() !== 6'b000000) begin
                failures++;
                $display("FAIL mid_hold_in_reset i=%0d got=%b exp=%b", i, obs(), 6'b000000);
            end
        end
        reset_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick(i < 2);
            if (i == 0)      exp = 6'b100001;
            else if (i == 1) exp = 6'b000001;
            else if (i == 2) exp = 6'b010000;
            else             exp = 6'b000000;
            checks++;
            if (obs() !== exp) begin
                failures++;
                $display("FAIL mid_hold_post i=%0d got=%b exp=%b", i, obs(), exp);
            end
        end
    endtask

    // Pattern 1,0,1,0: press, release, press, release on consecutive cycles.
    task automatic test_back_to_back();
        logic [5:0] exp;
        for (int i = 0; i < 5; i++) begin
            tick((i == 0) || (i == 2));
            if (i == 0 || i == 2)      exp = 6'b100001;
            else if (i == 1 || i == 3) exp = 6'b010000;
            else                       exp = 6'b000000;
            checks++;
            if (obs() !== exp) begin
                failures++;
                $display("FAIL back_to_back i=%0d got=%b exp=%b", i, obs(), exp);
            end
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        mon_en   = 1'b0;
        reset_n  = 1'b0;
        level_in = 1'b0;
        test_reset();
        test_short_press();
        test_long_and_repeat();
        test_threshold_release();
        test_reset_mid_hold();
        test_back_to_back();
        mon_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
